// File: rtl/mdp3_book_pkg.sv
// mdp3_book_pkg: shared types and constants for the MDP3 book snapshot egress stage
package mdp3_book_pkg;
  localparam int LEVEL_W = 128;
  localparam int BEAT_W  = 64;
  typedef struct packed {
    logic [63:0] price;
    logic [31:0] quantity;
    logic [31:0] num_orders;
  } level_t;
  typedef enum logic [1:0] {IDLE, HEADER, LEVELS} state_t;
  function automatic int frame_beats(input int depth);
    return 1 + 4 * depth;
  endfunction
endpackage

// File: rtl/book_snapshot_streamer.sv
// book_snapshot_streamer: freezes order-book snapshots and streams them as 64-bit Avalon-ST packets
module book_snapshot_streamer
  import mdp3_book_pkg::*;
#(
  parameter int DEPTH      = 10,
  parameter int DROP_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     snap_valid,
  input  logic [31:0]              security_id,
  input  logic [DEPTH*LEVEL_W-1:0] asks,
  input  logic [DEPTH*LEVEL_W-1:0] bids,
  output logic [BEAT_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [2:0]               out_empty,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [DROP_CNT_W-1:0]    drop_count
);
  localparam int BW   = $clog2(4 * DEPTH);
  localparam int LAST = frame_beats(DEPTH) - 2;
  state_t                   state_q, state_d;
  logic [BW-1:0]            beat_q, beat_d, lvl_sel;
  logic [31:0]              seq_q, seq_d, hdr_seq_q, hdr_seq_d, sec_q, sec_d;
  logic [DEPTH*LEVEL_W-1:0] asks_q, asks_d, bids_q, bids_d;
  logic [DROP_CNT_W-1:0]    drop_q, drop_d;
  logic                     busy_q, busy_d, hs, last, capture;
  level_t                   lvl;
  assign out_valid  = state_q != IDLE;
  assign out_sop    = state_q == HEADER;
  assign out_eop    = state_q == LEVELS && beat_q == BW'(LAST);
  assign out_empty  = '0;
  assign busy       = busy_q;
  assign drop_count = drop_q;
  assign hs         = out_valid && out_ready;
  assign last       = out_eop && hs;
  // a snapshot arriving on the final handshake starts the next frame with no idle gap
  assign capture    = snap_valid && (state_q == IDLE || last);
  always_comb begin
    lvl_sel  = beat_q < BW'(2 * DEPTH) ? beat_q >> 1 : (beat_q - BW'(2 * DEPTH)) >> 1;
    lvl      = beat_q < BW'(2 * DEPTH) ? asks_q[lvl_sel*LEVEL_W +: LEVEL_W] : bids_q[lvl_sel*LEVEL_W +: LEVEL_W];
    out_data = state_q == HEADER ? {sec_q, hdr_seq_q} :
               state_q == LEVELS ? (beat_q[0] ? {lvl.quantity, lvl.num_orders} : lvl.price) : '0;
  end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    seq_d   = last ? seq_q + 32'd1 : seq_q;
    if (state_q == HEADER && hs) begin
      state_d = LEVELS;
      beat_d  = '0;
    end
    if (state_q == LEVELS && hs) begin
      beat_d  = last ? '0 : beat_q + 1'b1;
      state_d = last ? IDLE : LEVELS;
    end
    if (capture) state_d = HEADER;
    sec_d     = capture ? security_id : sec_q;
    asks_d    = capture ? asks : asks_q;
    bids_d    = capture ? bids : bids_q;
    hdr_seq_d = capture ? seq_d : hdr_seq_q;
    drop_d    = snap_valid && !capture && drop_q != '1 ? drop_q + 1'b1 : drop_q;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      seq_q     <= '0;
      hdr_seq_q <= '0;
      sec_q     <= '0;
      asks_q    <= '0;
      bids_q    <= '0;
      drop_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      seq_q     <= seq_d;
      hdr_seq_q <= hdr_seq_d;
      sec_q     <= sec_d;
      asks_q    <= asks_d;
      bids_q    <= bids_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end
endmodule

// File: tb/tb_book_snapshot_streamer.sv
// tb_book_snapshot_streamer: randomized bench checking the streamer against a frame-level reference model
module tb_book_snapshot_streamer;
  localparam int D  = 10;
  localparam int NB = 1 + 4 * D;
  logic             clk = 0, reset_n = 0, snap_valid = 0, out_ready = 0;
  logic [31:0]      security_id = '0;
  logic [D*128-1:0] asks = '0, bids = '0;
  logic [63:0]      out_data;
  logic             out_valid, out_sop, out_eop, busy;
  logic [2:0]       out_empty;
  logic [15:0]      drop_count;
  int               n_chk = 0, n_fail = 0, hs_cnt = 0;

  book_snapshot_streamer #(.DEPTH(D), .DROP_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .snap_valid(snap_valid), .security_id(security_id),
    .asks(asks), .bids(bids), .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty), .out_ready(out_ready), .busy(busy),
    .drop_count(drop_count));

  always #5 clk = ~clk;

  // reference model: a frame is a flat list of beats built from the snapshot at capture time
  bit          m_busy = 0, m_last;
  int          m_idx = 0;
  logic [63:0] m_frame[NB];
  logic [31:0] m_seq = 0;
  logic [15:0] m_drops = 0;

  function automatic void build(input logic [31:0] sec, input logic [31:0] sq);
    m_frame[0] = {sec, sq};
    for (int l = 0; l < D; l++) begin
      m_frame[1 + 2*l]       = asks[128*l + 64 +: 64];
      m_frame[2 + 2*l]       = asks[128*l +: 64];
      m_frame[1 + 2*D + 2*l] = bids[128*l + 64 +: 64];
      m_frame[2 + 2*D + 2*l] = bids[128*l +: 64];
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_idx = 0; m_seq = 0; m_drops = 0;
    end else if (!m_busy) begin
      if (snap_valid) begin build(security_id, m_seq); m_busy = 1; m_idx = 0; end
    end else begin
      m_last = out_ready && m_idx == NB - 1;
      if (snap_valid && !m_last && m_drops != 16'hFFFF) m_drops = m_drops + 1;
      if (out_ready) begin
        if (m_last) begin
          m_seq  = m_seq + 1;
          m_idx  = 0;
          m_busy = snap_valid;
          if (snap_valid) build(security_id, m_seq);
        end else m_idx = m_idx + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    chk("out_valid", out_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("drop_count", drop_count, m_drops);
    chk("out_empty", out_empty, 0);
    chk("out_data", out_data, m_busy ? m_frame[m_idx] : 64'h0);
    chk("out_sop", out_sop, m_busy && m_idx == 0);
    chk("out_eop", out_eop, m_busy && m_idx == NB - 1);
    if (out_valid && out_ready) hs_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rand_snap();
    security_id = $urandom;
    for (int i = 0; i < 4*D; i++) begin
      asks[32*i +: 32] = $urandom;
      bids[32*i +: 32] = $urandom;
    end
  endtask

  task automatic pulse();
    snap_valid = 1; step(); snap_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin step(); n++; end
    if (m_busy) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: frame still busy after %0d cycles", budget);
    end
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (m_idx != idx && n < 1000) begin step(); n++; end
    if (m_idx != idx) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idx: beat %0d not reached, at %0d", idx, m_idx);
    end
  endtask

  task automatic do_reset();
    reset_n = 0; step(); reset_n = 1; step();
  endtask

  initial begin
    int hs0;
    step(); step();
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset drop_count", drop_count, 0);
    chk("reset out_data", out_data, 0);
    reset_n = 1; step();
    // single directed snapshot with literal expectations
    out_ready = 1; security_id = 32'h1234;
    asks[127:0] = {64'h100, 32'd5, 32'd2};
    pulse();
    chk("m beat1", m_frame[1], 64'h0000000000000100);
    chk("m beat2", m_frame[2], 64'h0000000500000002);
    chk("hdr data", out_data, 64'h0000123400000000);
    chk("hdr sop", out_sop, 1);
    step(); chk("beat1 data", out_data, 64'h0000000000000100);
    step(); chk("beat2 data", out_data, 64'h0000000500000002);
    wait_idle(100);
    chk("m seq after frame", m_seq, 1);
    // random backpressure
    for (int f = 0; f < 4; f++) begin
      rand_snap(); out_ready = 1; pulse();
      hs0 = hs_cnt;
      for (int n = 0; n < 600 && m_busy; n++) begin out_ready = $urandom_range(0, 1); step(); end
      out_ready = 1; wait_idle(100);
      chk("accepted beats", hs_cnt - hs0, NB);
    end
    // snapshots while busy are dropped
    do_reset();
    rand_snap(); pulse();
    for (int n = 0; n < 100 && m_busy; n++) begin
      snap_valid = m_idx == 10 || m_idx == 20;
      if (snap_valid) rand_snap();
      step();
    end
    snap_valid = 0;
    chk("two drops", drop_count, 2);
    // back-to-back on the eop handshake
    do_reset();
    rand_snap(); pulse();
    wait_idx(NB - 1);
    rand_snap(); snap_valid = 1; step(); snap_valid = 0;
    chk("b2b sop", out_sop, 1);
    chk("b2b seq", out_data[31:0], 1);
    chk("b2b drops", drop_count, 0);
    wait_idle(100);
    // asynchronous reset mid-frame
    rand_snap(); pulse();
    wait_idx(5); snap_valid = 1; step(); snap_valid = 0;
    wait_idx(15);
    reset_n = 0; #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst sop", out_sop, 0);
    chk("arst eop", out_eop, 0);
    chk("arst busy", busy, 0);
    chk("arst drop_count", drop_count, 0);
    step(); step(); reset_n = 1; step();
    rand_snap(); pulse();
    chk("post-reset seq", out_data[31:0], 0);
    wait_idle(100);
    // drop counter saturation
    force dut.drop_q = 16'hFFF0; m_drops = 16'hFFF0;
    step(); release dut.drop_q;
    out_ready = 0; rand_snap(); pulse();
    snap_valid = 1;
    for (int n = 0; n < 20; n++) step();
    snap_valid = 0;
    chk("drop saturated", drop_count, 16'hFFFF);
    out_ready = 1; wait_idle(100);
    // seq_num wrap
    force dut.seq_q = 32'hFFFFFFFF; m_seq = 32'hFFFFFFFF;
    step(); release dut.seq_q;
    rand_snap(); pulse();
    chk("max seq hdr", out_data[31:0], 32'hFFFFFFFF);
    wait_idle(100);
    rand_snap(); pulse();
    chk("wrapped seq hdr", out_data[31:0], 0);
    wait_idle(100);
    // randomized mix of snapshots and backpressure
    for (int n = 0; n < 3000; n++) begin
      snap_valid = $urandom_range(0, 9) == 0;
      if (snap_valid) rand_snap();
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    snap_valid = 0; out_ready = 1;
    wait_idle(200);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/book_snapshot_streamer.md
Name: book_snapshot_streamer

Overview:
- Consumes top-of-book snapshots from the order book stage: DEPTH ask levels, DEPTH bid levels and the security ID, qualified by a one-cycle ready pulse.
- Freezes each snapshot into a shadow register and serialises it as one 64-bit Avalon-ST source packet toward the host/DMA side.
- Sits directly downstream of the order book and is the egress stage of the MDP3 streamer pipeline.

Parameters:
- DEPTH, 10, book levels per side.
- DROP_CNT_W, 16, width of the saturating dropped-snapshot counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- snap_valid  in  1  one-cycle pulse from the order book; the snapshot inputs are valid in this cycle.
- security_id  in  32  security of the snapshot.
- asks  in  DEPTH*128  ask level i at bits [128*i+127:128*i]; each level is {price[63:0], quantity[31:0], num_orders[31:0]}, MSB first.
- bids  in  DEPTH*128  same layout as asks.
- out_data  out  64  Avalon-ST data.
- out_valid  out  1  Avalon-ST valid.
- out_sop  out  1  start of packet.
- out_eop  out  1  end of packet.
- out_empty  out  3  always 0, because every beat is full.
- out_ready  in  1  Avalon-ST ready, ready latency 0.
- busy  out  1  high while a frame is pending or in transmission.
- drop_count  out  DROP_CNT_W  number of snapshots dropped because the block was busy; saturates.

Behaviour:
- Frame format, 1+4*DEPTH beats (41 at default):
  - beat 0: {security_id, seq_num}.
  - asks, level 0 to DEPTH-1, two beats each: level[127:64], then level[63:0].
  - bids, same order and beat layout.
- Reset values: all outputs 0 (out_data, out_valid, out_sop, out_eop, busy, drop_count); seq_num is 0; state is IDLE. Reset is asynchronous and forces these values mid-frame with no completion of the packet.
- States:
  - IDLE: snap_valid=1 captures security_id, asks, bids and the current seq_num into the shadow register, then goes to HEADER.
  - HEADER: out_valid=1, out_sop=1. On out_valid&&out_ready go to LEVELS with beat_idx=0.
  - LEVELS: beat_idx runs 0..4*DEPTH-1.
    - beat_idx<2*DEPTH selects ask level beat_idx>>1; otherwise bid level (beat_idx-2*DEPTH)>>1.
    - Even beat_idx sends the high half; odd sends the low half.
    - out_eop=1 when beat_idx=4*DEPTH-1.
    - On the last beat's handshake: seq_num increments (wraps modulo 2^32) and the state returns to IDLE.
- Latency: first beat presented the cycle after the snap_valid capture. Minimum frame duration is 1+4*DEPTH cycles when out_ready is held high.
- Backpressure: while out_valid&&!out_ready, out_data, out_sop and out_eop hold stable and beat_idx does not advance. out_valid never deasserts mid-frame.
- busy = (state != IDLE), registered.
- Input ignored while busy: snap_valid in HEADER or LEVELS is not captured, except on the cycle of the last beat's handshake (see next bullet). drop_count increments by 1 per ignored snap_valid and saturates at all-ones. The shadow register is never disturbed mid-frame.
- Capture on last handshake: snap_valid on the same cycle as the last beat's handshake is captured, not dropped. The next state is HEADER and the new frame carries the incremented seq_num. This gives back-to-back frames with no idle cycle.
- Boundary conditions:
  - out_ready held low indefinitely: the block stalls and snapshots keep being counted as dropped.
  - drop_count at saturation stays at max.
  - seq_num 0xFFFFFFFF wraps to 0 after its frame completes.

Decomposition:
- Package mdp3_book_pkg:
  - level_t packed struct {price 64, quantity 32, num_orders 32}.
  - LEVEL_W=128, BEAT_W=64.
  - state enum {IDLE, HEADER, LEVELS}.
  - localparam function frame_beats(depth)=1+4*depth.
- No sub-module is warranted. The beat-select mux is a combinational always block inside the module.

Test Plan:
- Single snapshot, out_ready=1: security_id=0x1234, ask0={price 0x100, qty 5, orders 2}, others 0 -> 41 beats. Beat0={0x00001234, 0x00000000} with sop; beat1=0x0000000000000100; beat2=0x0000000500000002; eop only on beat 40; next frame's seq_num=1.
- Backpressure: toggle out_ready 1,0,0,1,... randomly -> data/sop/eop stable during stalls, exactly 41 accepted beats, values identical to the no-stall run.
- Snapshot while busy: snap_valid at beat 10 and beat 20 -> drop_count=2, frame content unchanged (still first snapshot), busy=1 throughout.
- Back-to-back: snap_valid on the cycle of the eop handshake -> next cycle sop beat of the second frame, seq_num=1, drop_count=0.
- Reset mid-frame: assert reset_n=0 at beat 15 -> out_valid, sop, eop, busy and drop_count go 0 asynchronously. After release, a new snap_valid produces a frame with seq_num=0.
- Saturation/wrap: preload drop_count=0xFFFF via drops, one more drop -> stays 0xFFFF. Force seq_num=0xFFFFFFFF, one frame -> next header seq_num=0.
